// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   EX-stage execute unit behind a valid/ready handshake. ADD, SUB, AND, OR,
//   XOR and SLT finish in the accept cycle. SLL, SRL and SRA move the result by
//   one bit per cycle, and the unit holds in_ready low while a shift runs.
//   The result and the Zero/Negative/Carry/OverFlow flags are registered. They
//   stay stable in DONE until the downstream stage takes them.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-low
//   in_valid    operation request
//   in_ready    unit can accept an operation (IDLE and out of reset)
//   ALUControl  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT,
//               110 SLL, 111 shift right
//   sra_sel     with 111: 1 = arithmetic right, 0 = logical right
//   A, B        operands; the shift amount is B[$clog2(WIDTH)-1:0]
//   out_valid   Result and flags valid
//   out_ready   downstream accepts the result
//   Result      registered result
//   Zero, Negative, Carry, OverFlow  registered flags
// -----------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic             sra_sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             OverFlow
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRX = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic [SHW-1:0]   r_count;
  logic [2:0]       r_op;
  logic             r_sra;
  logic             r_out_valid;
  logic             r_zero;
  logic             r_neg;
  logic             r_carry;
  logic             r_ovf;

  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;
  logic             w_is_shift;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_shift_next;

  // Adder with carry-in. It returns {overflow, carry_out, sum}. The caller
  // passes the operand already inverted for SUB, so one overflow rule covers
  // both ADD and SUB.
  function automatic logic [WIDTH+1:0] add_flags(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             cin
  );
    logic [WIDTH:0] sum_ext;
    logic           ovf;
    sum_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    ovf     = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
    return {ovf, sum_ext[WIDTH], sum_ext[WIDTH-1:0]};
  endfunction

  assign in_ready   = (r_state == ST_IDLE) && rst;
  assign w_is_shift = (ALUControl == OP_SLL) || (ALUControl == OP_SRX);
  assign w_shamt    = B[SHW-1:0];

  // Single-cycle datapath for the non-shift codes, evaluated on the live inputs
  always_comb begin
    logic [WIDTH+1:0] sum_v;
    w_alu_res = {WIDTH{1'b0}};
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    sum_v     = {(WIDTH+2){1'b0}};
    case (ALUControl)
      OP_ADD: begin
        sum_v     = add_flags(A, B, 1'b0);
        w_alu_res = sum_v[WIDTH-1:0];
        w_alu_c   = sum_v[WIDTH];
        w_alu_v   = sum_v[WIDTH+1];
      end
      OP_SUB: begin
        sum_v     = add_flags(A, ~B, 1'b1);
        w_alu_res = sum_v[WIDTH-1:0];
        w_alu_c   = sum_v[WIDTH];
        w_alu_v   = sum_v[WIDTH+1];
      end
      OP_AND: w_alu_res = A & B;
      OP_OR:  w_alu_res = A | B;
      OP_XOR: w_alu_res = A ^ B;
      OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: begin
        w_alu_res = {WIDTH{1'b0}};
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
      end
    endcase
  end

  // One-bit shift step applied to the held result while in SHIFT
  always_comb begin
    w_shift_next = r_result;
    case (r_op)
      OP_SLL: w_shift_next = {r_result[WIDTH-2:0], 1'b0};
      OP_SRX: begin
        if (r_sra) begin
          w_shift_next = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
        end else begin
          w_shift_next = {1'b0, r_result[WIDTH-1:1]};
        end
      end
      default: w_shift_next = r_result;
    endcase
  end

  // Control FSM with registered result, flags and out_valid
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_result    <= {WIDTH{1'b0}};
      r_count     <= {SHW{1'b0}};
      r_op        <= 3'b000;
      r_sra       <= 1'b0;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_out_valid <= 1'b0;
          // in_ready equals IDLE while rst is high, so in_valid here is an accept
          if (in_valid) begin
            r_op  <= ALUControl;
            r_sra <= sra_sel;
            if (w_is_shift) begin
              r_result <= A;
              r_count  <= w_shamt;
              r_carry  <= 1'b0;
              r_ovf    <= 1'b0;
              if (w_shamt == {SHW{1'b0}}) begin
                // A zero shift amount passes A straight through
                r_zero      <= (A == {WIDTH{1'b0}});
                r_neg       <= A[WIDTH-1];
                r_out_valid <= 1'b1;
                r_state     <= ST_DONE;
              end else begin
                r_state <= ST_SHIFT;
              end
            end else begin
              r_result    <= w_alu_res;
              r_carry     <= w_alu_c;
              r_ovf       <= w_alu_v;
              r_zero      <= (w_alu_res == {WIDTH{1'b0}});
              r_neg       <= w_alu_res[WIDTH-1];
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_result <= w_shift_next;
          r_count  <= r_count - SHW'(1);
          // Count reaches zero with this step, so this shifted value is final
          if (r_count == SHW'(1)) begin
            r_zero      <= (w_shift_next == {WIDTH{1'b0}});
            r_neg       <= w_shift_next[WIDTH-1];
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_state <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign Result    = r_result;
  assign Zero      = r_zero;
  assign Negative  = r_neg;
  assign Carry     = r_carry;
  assign OverFlow  = r_ovf;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUControl;
  logic        sra_sel;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Zero;
  logic        Negative;
  logic        Carry;
  logic        OverFlow;

  int n_cmp = 0;
  int n_err = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUControl(ALUControl),
    .sra_sel   (sra_sel),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Zero      (Zero),
    .Negative  (Negative),
    .Carry     (Carry),
    .OverFlow  (OverFlow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Request at a negedge, then count negedges until out_valid.
  // Flags are packed as {Zero, Negative, Carry, OverFlow}.
  task automatic do_op(input string tag, input logic [2:0] code, input logic sra,
                       input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                       input logic [31:0] exp_res, input logic [3:0] exp_f);
    int   lat;
    logic busy_ok;
    @(negedge clk);
    chk({tag, ".rdy"}, {31'd0, in_ready}, 32'd1);
    ALUControl = code;
    sra_sel    = sra;
    A          = a;
    B          = b;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A        = 32'hDEAD_BEEF;
    B        = 32'hDEAD_BEEF;
    lat      = 1;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 64) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (in_ready) busy_ok = 1'b0;
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".res"}, Result, exp_res);
    chk({tag, ".flg"}, {28'd0, Zero, Negative, Carry, OverFlow}, {28'd0, exp_f});
    chk({tag, ".busy"}, {31'd0, busy_ok}, 32'd1);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".ov0"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".ir1"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic stable_ok;
    logic no_valid;

    rst        = 1'b0;
    in_valid   = 1'b1;
    ALUControl = 3'b000;
    sra_sel    = 1'b0;
    A          = 32'h0000_0003;
    B          = 32'h0000_0004;
    out_ready  = 1'b0;

    // Hold reset for 3 cycles while a request is presented
    repeat (3) @(negedge clk);
    chk("rst.ir", {31'd0, in_ready}, 32'd0);
    chk("rst.ov", {31'd0, out_valid}, 32'd0);
    chk("rst.res", Result, 32'd0);
    chk("rst.flg", {28'd0, Zero, Negative, Carry, OverFlow}, 32'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk("rst.noacc", {31'd0, out_valid}, 32'd0);
    chk("rst.res2", Result, 32'd0);

    do_op("add_ovf", 3'b000, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 4'b0101);
    consume("add_ovf");
    do_op("sub_eq", 3'b001, 1'b0, 32'h0000_0005, 32'h0000_0005, 1, 32'h0000_0000, 4'b1010);
    consume("sub_eq");
    do_op("sub_brw", 3'b001, 1'b0, 32'h0000_0000, 32'h0000_0001, 1, 32'hFFFF_FFFF, 4'b0100);
    consume("sub_brw");
    do_op("sub_ovf", 3'b001, 1'b0, 32'h8000_0000, 32'h0000_0001, 1, 32'h7FFF_FFFF, 4'b0011);
    consume("sub_ovf");
    do_op("add_cy", 3'b000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000, 4'b1010);
    consume("add_cy");
    do_op("slt_t", 3'b101, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0001, 4'b0000);
    consume("slt_t");
    do_op("slt_f", 3'b101, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1, 32'h0000_0000, 4'b1000);
    consume("slt_f");
    do_op("and", 3'b010, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'h00F0_00F0, 4'b0000);
    consume("and");
    do_op("or", 3'b011, 1'b0, 32'h0F00_0000, 32'h0000_00F0, 1, 32'h0F00_00F0, 4'b0000);
    consume("or");
    do_op("xor", 3'b100, 1'b0, 32'h1234_5678, 32'h1234_5678, 1, 32'h0000_0000, 4'b1000);
    consume("xor");
    do_op("sra4", 3'b111, 1'b1, 32'h8000_0000, 32'h0000_0004, 5, 32'hF800_0000, 4'b0100);
    consume("sra4");
    do_op("srl4", 3'b111, 1'b0, 32'h8000_0000, 32'h0000_0004, 5, 32'h0800_0000, 4'b0000);
    consume("srl4");
    do_op("sll31", 3'b110, 1'b0, 32'h0000_0001, 32'h0000_001F, 32, 32'h8000_0000, 4'b0100);
    consume("sll31");
    do_op("sh0", 3'b110, 1'b0, 32'h1234_5678, 32'h0000_0020, 1, 32'h1234_5678, 4'b0000);
    consume("sh0");

    // Backpressure: DONE must hold everything while out_ready stays low
    do_op("bp", 3'b000, 1'b0, 32'h0000_0003, 32'h0000_0004, 1, 32'h0000_0007, 4'b0000);
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || Result !== 32'h0000_0007 ||
          {Zero, Negative, Carry, OverFlow} !== 4'b0000) stable_ok = 1'b0;
    end
    chk("bp.stable", {31'd0, stable_ok}, 32'd1);
    consume("bp");

    // Reset asserted in the middle of a shift discards the operation
    @(negedge clk);
    ALUControl = 3'b110;
    sra_sel    = 1'b0;
    A          = 32'h0000_0001;
    B          = 32'h0000_0014;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid.ir", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    no_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) no_valid = 1'b0;
    end
    chk("mid.nov", {31'd0, no_valid}, 32'd1);
    chk("mid.res", Result, 32'd0);
    chk("mid.ir1", {31'd0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
